// File: rtl/stride_ctrl_pkg.sv
// rtl/stride_ctrl_pkg.sv - shared state encoding and sweep-end helper for stride_ctrl
package stride_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_WRAP  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // Last counter position of a sweep: all-ones at the given width.
    function automatic logic [31:0] pos_last(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/stride_ctrl_if.sv
// rtl/stride_ctrl_if.sv - command, source/destination handshake and counter-side signals of stride_ctrl
interface stride_ctrl_if;

    logic       start;
    logic       src_valid;
    logic       src_pair;
    logic       dst_ready;
    logic       co_in;
    logic       cnt_en1;
    logic       cnt_en2;
    logic       cnt_clr;
    logic       busy;
    logic       done;
    logic [7:0] pass_idx;
    logic       err;

    modport master (
        output start, src_valid, src_pair, dst_ready, co_in,
        input  cnt_en1, cnt_en2, cnt_clr, busy, done, pass_idx, err
    );

    modport slave (
        input  start, src_valid, src_pair, dst_ready, co_in,
        output cnt_en1, cnt_en2, cnt_clr, busy, done, pass_idx, err
    );

endinterface

// File: rtl/stride_ctrl_fsm.sv
// rtl/stride_ctrl_fsm.sv - sweep sequencer state register with registered clear/busy/done
module stride_ctrl_fsm
    import stride_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  logic   at_last,
    input  logic   last_pass,
    output state_t state,
    output logic   cnt_clr,
    output logic   busy,
    output logic   done
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            cnt_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_CLEAR;
                        cnt_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_CLEAR: state <= ST_RUN;
                ST_RUN: begin
                    if (at_last) state <= ST_WRAP;
                end
                ST_WRAP: begin
                    // Outputs are registered, so they are set on the edge entering their state.
                    if (last_pass) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end else begin
                        state   <= ST_CLEAR;
                        cnt_clr <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/stride_ctrl.sv
// rtl/stride_ctrl.sv - +1/+2 enable generator and multi-sweep sequencer for the dual-stride counter
// Optional co/shadow-position consistency check built when STRIDE_CTRL_CHECK_EN is defined.
module stride_ctrl
    import stride_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int PASSES = 2
) (
    input  logic         clk,
    input  logic         rst,
    stride_ctrl_if.slave bus
);

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(pos_last(WIDTH));
    localparam logic [WIDTH-1:0] LAST_M2 = LAST - WIDTH'(2);
    localparam logic [7:0]       PASS_END = 8'(PASSES - 1);

    state_t           state;
    logic [WIDTH-1:0] pos;
    logic [7:0]       pass_idx;
    logic             at_last;
    logic             last_pass;
    logic             xfer;
    logic             take2;

    assign at_last   = (pos == LAST);
    assign last_pass = (pass_idx == PASS_END);

    // pos tracks the counter; a +2 is only allowed when it cannot overshoot all-ones.
    assign xfer  = (state == ST_RUN) && !at_last && bus.src_valid && bus.dst_ready;
    assign take2 = xfer && bus.src_pair && (pos <= LAST_M2);

    assign bus.cnt_en2  = take2;
    assign bus.cnt_en1  = xfer && !take2;
    assign bus.pass_idx = pass_idx;

    stride_ctrl_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .start     (bus.start),
        .at_last   (at_last),
        .last_pass (last_pass),
        .state     (state),
        .cnt_clr   (bus.cnt_clr),
        .busy      (bus.busy),
        .done      (bus.done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else if (state == ST_CLEAR) begin
            pos <= '0;
        end else if (take2) begin
            pos <= pos + WIDTH'(2);
        end else if (xfer) begin
            pos <= pos + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_idx <= '0;
        end else if (state == ST_WRAP && !last_pass) begin
            pass_idx <= pass_idx + 8'd1;
        end else if (state == ST_FIN) begin
            pass_idx <= '0;
        end
    end

`ifdef STRIDE_CTRL_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state == ST_RUN || state == ST_WRAP) && (bus.co_in != at_last)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_co;
    assign unused_co = bus.co_in;
    assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_stride_ctrl.sv
// tb/tb_stride_ctrl.sv - directed self-checking bench for stride_ctrl (WIDTH=3, PASSES=3)
module tb_stride_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic co_force;
    logic [2:0] cnt;
    logic [3:0] pat;
    logic exp_err;
    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    int n_clr = 0;
    int exp_pos;
    int k;

    always #5 clk = ~clk;

    stride_ctrl_if bus ();

    stride_ctrl #(.WIDTH(3), .PASSES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference dual-stride counter; cnt_clr is ORed into its reset as in the parent.
    always @(posedge clk or posedge rst) begin
        if (rst)              cnt <= 3'd0;
        else if (bus.cnt_clr) cnt <= 3'd0;
        else if (bus.cnt_en2) cnt <= cnt + 3'd2;
        else if (bus.cnt_en1) cnt <= cnt + 3'd1;
    end

    assign bus.co_in = co_force | (cnt == 3'd7);

    always @(posedge clk) begin
        if (bus.done)    n_done <= n_done + 1;
        if (bus.cnt_clr) n_clr  <= n_clr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic outs(input string tag, input logic e1, input logic e2, input logic clr,
                        input logic dn, input logic bsy);
        chk({tag, ".en1"},  32'(bus.cnt_en1), 32'(e1));
        chk({tag, ".en2"},  32'(bus.cnt_en2), 32'(e2));
        chk({tag, ".clr"},  32'(bus.cnt_clr), 32'(clr));
        chk({tag, ".done"}, 32'(bus.done),    32'(dn));
        chk({tag, ".busy"}, 32'(bus.busy),    32'(bsy));
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
`ifdef STRIDE_CTRL_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        pat = 4'b1001;
        rst = 1'b1;
        co_force = 1'b0;
        bus.start = 1'b0;
        bus.src_valid = 1'b0;
        bus.src_pair = 1'b0;
        bus.dst_ready = 1'b0;
        repeat (2) step;
        rst = 1'b0;
        bus.src_valid = 1'b1;
        bus.dst_ready = 1'b1;
        #1;
        outs("reset", 0, 0, 0, 0, 0);
        chk("reset.pass", 32'(bus.pass_idx), 0);
        chk("reset.err", 32'(bus.err), 0);
        step;
        outs("idle", 0, 0, 0, 0, 0);

        // Sweep 0: single strides
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        outs("clr0", 0, 0, 1, 0, 1);
        for (int i = 0; i < 7; i++) begin
            step;
            outs($sformatf("s0_%0d", i), 1, 0, 0, 0, 1);
            chk($sformatf("s0_pos%0d", i), 32'(cnt), 32'(i));
        end
        step;
        outs("s0_hold", 0, 0, 0, 0, 1);
        chk("s0_co", 32'(bus.co_in), 1);
        step;
        outs("s0_wrap", 0, 0, 0, 0, 1);
        chk("s0_wrap.pass", 32'(bus.pass_idx), 0);
        step;
        outs("clr1", 0, 0, 1, 0, 1);
        chk("clr1.pass", 32'(bus.pass_idx), 1);

        // Sweep 1: pairs available, last step must fall back to +1
        bus.src_pair = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            outs($sformatf("s1_%0d", i), 0, 1, 0, 0, 1);
            chk($sformatf("s1_pos%0d", i), 32'(cnt), 32'(2 * i));
        end
        step;
        outs("s1_3", 1, 0, 0, 0, 1);
        chk("s1_pos3", 32'(cnt), 6);
        step;
        outs("s1_hold", 0, 0, 0, 0, 1);
        chk("s1_pos4", 32'(cnt), 7);
        chk("s1_co", 32'(bus.co_in), 1);
        step;
        outs("s1_wrap", 0, 0, 0, 0, 1);
        step;
        outs("clr2", 0, 0, 1, 0, 1);
        chk("clr2.pass", 32'(bus.pass_idx), 2);

        // Sweep 2: dst_ready pattern 1,0,0,1 with a start pulse that must be ignored
        bus.src_pair = 1'b0;
        step;
        exp_pos = 0;
        k = 0;
        while (exp_pos < 7 && k < 40) begin
            bus.dst_ready = pat[k % 4];
            bus.start = (k == 1);
            #1;
            chk($sformatf("s2_en1_%0d", k), 32'(bus.cnt_en1), 32'(pat[k % 4]));
            chk($sformatf("s2_pos_%0d", k), 32'(cnt), 32'(exp_pos));
            if (pat[k % 4]) exp_pos++;
            step;
            k++;
        end
        bus.dst_ready = 1'b1;
        bus.start = 1'b0;
        #1;
        chk("s2_bound", 32'(exp_pos), 7);
        outs("s2_hold", 0, 0, 0, 0, 1);
        chk("s2_pos", 32'(cnt), 7);
        step;
        outs("s2_wrap", 0, 0, 0, 0, 1);
        step;
        outs("fin", 0, 0, 0, 1, 1);
        chk("fin.pass", 32'(bus.pass_idx), 2);
        step;
        outs("idle2", 0, 0, 0, 0, 0);
        chk("idle2.pass", 32'(bus.pass_idx), 0);
        chk("done_count", 32'(n_done), 1);
        chk("clr_count", 32'(n_clr), 3);
        chk("err_clean", 32'(bus.err), 0);

        // Async reset at pos=4 mid-sweep, then replay from 0
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) step;
        chk("pre_rst.pos", 32'(cnt), 4);
        chk("pre_rst.en1", 32'(bus.cnt_en1), 1);
        rst = 1'b1;
        #1;
        outs("rst_mid", 0, 0, 0, 0, 0);
        chk("rst_mid.pass", 32'(bus.pass_idx), 0);
        step;
        rst = 1'b0;
        step;
        outs("rst_idle", 0, 0, 0, 0, 0);
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        outs("replay_clr", 0, 0, 1, 0, 1);
        step;
        outs("replay_0", 1, 0, 0, 0, 1);
        chk("replay.pos", 32'(cnt), 0);

        // Inject a false carry at pos=3
        repeat (3) step;
        chk("inj.pos", 32'(cnt), 3);
        chk("inj.err0", 32'(bus.err), 0);
        co_force = 1'b1;
        step;
        co_force = 1'b0;
        chk("err_rise", 32'(bus.err), 32'(exp_err));
        repeat (3) step;
        chk("err_sticky", 32'(bus.err), 32'(exp_err));
        rst = 1'b1;
        #1;
        chk("err_rst", 32'(bus.err), 0);
        step;
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
